// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared constants for the address register file interface and the fetch sequencer.
package instruction_fetch_sequencer_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned IR_W     = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned FUN_W    = 3;
    localparam int unsigned REGSEL_W = 3;
    localparam int unsigned OUTSEL_W = 2;

    localparam logic [FUN_W-1:0] FUN_DEC  = 3'b000;
    localparam logic [FUN_W-1:0] FUN_INC  = 3'b001;
    localparam logic [FUN_W-1:0] FUN_LOAD = 3'b010;
    localparam logic [FUN_W-1:0] FUN_CLR  = 3'b011;

    // Active-low enables ordered {PC, AR, SP}
    localparam logic [REGSEL_W-1:0] REGSEL_NONE = 3'b111;
    localparam logic [REGSEL_W-1:0] REGSEL_PC   = 3'b011;
    localparam logic [REGSEL_W-1:0] REGSEL_AR   = 3'b101;
    localparam logic [REGSEL_W-1:0] REGSEL_SP   = 3'b110;

    localparam logic [OUTSEL_W-1:0] OUTSEL_PC = 2'b00;

    typedef struct packed {
        logic [FUN_W-1:0]    fun_sel;
        logic [REGSEL_W-1:0] reg_sel;
    } arf_ctrl_t;

endpackage

// File: rtl/instruction_fetch_sequencer_timeout_counter.sv
// Per-request wait counter; flags the last permitted no-ack cycle so the FSM can abort.
module instruction_fetch_sequencer_timeout_counter
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // This no-ack cycle brings the count to TIMEOUT; an ack in the same cycle disables it
    assign expired_c = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch from byte memory, stepping PC through the address register file.
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          AUTO_FETCH = 1'b0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [ADDR_W-1:0]   ArfOutD,
    output logic [OUTSEL_W-1:0] ArfOutDSel,
    output logic [FUN_W-1:0]    ArfFunSel,
    output logic [REGSEL_W-1:0] ArfRegSel,
    output logic                MemReq,
    output logic [ADDR_W-1:0]   MemAddr,
    input  logic                MemAck,
    input  logic [BYTE_W-1:0]   MemData,
    output logic [IR_W-1:0]     IR,
    output logic                IRValid,
    input  logic                IRConsume,
    output logic                Busy,
    output logic                Error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_LO,
        ST_INC_LO,
        ST_REQ_HI,
        ST_INC_HI,
        ST_VALID
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;
    arf_ctrl_t    ctrl_next;
    logic         in_req;
    logic         expired_c;
    logic         abort;

    assign in_req = (state == ST_REQ_LO) || (state == ST_REQ_HI);
    assign abort  = in_req && expired_c;

    instruction_fetch_sequencer_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (Clock),
        .rst_n    (Reset),
        .clear    (!in_req),
        .enable   (in_req && !MemAck),
        .expired_c(expired_c)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        ctrl_next.fun_sel = FUN_DEC;
        ctrl_next.reg_sel = REGSEL_NONE;
        unique case (state)
            ST_IDLE:   if (Start) state_next = ST_REQ_LO;
            ST_REQ_LO: begin
                if (MemAck)      state_next = ST_INC_LO;
                else if (abort)  state_next = ST_IDLE;
            end
            ST_INC_LO: state_next = ST_REQ_HI;
            ST_REQ_HI: begin
                if (MemAck)      state_next = ST_INC_HI;
                else if (abort)  state_next = ST_IDLE;
            end
            ST_INC_HI: state_next = ST_VALID;
            ST_VALID:  if (IRConsume) state_next = AUTO_FETCH ? ST_REQ_LO : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (state_next == ST_INC_LO || state_next == ST_INC_HI) begin
            ctrl_next.fun_sel = FUN_INC;
            ctrl_next.reg_sel = REGSEL_PC;
        end
    end

    // Outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            IR        <= '0;
            IRValid   <= 1'b0;
            MemReq    <= 1'b0;
            Busy      <= 1'b0;
            Error     <= 1'b0;
            ArfFunSel <= FUN_DEC;
            ArfRegSel <= REGSEL_NONE;
        end else begin
            MemReq    <= (state_next == ST_REQ_LO) || (state_next == ST_REQ_HI);
            Busy      <= (state_next != ST_IDLE);
            IRValid   <= (state_next == ST_VALID);
            ArfFunSel <= ctrl_next.fun_sel;
            ArfRegSel <= ctrl_next.reg_sel;
            if (state == ST_REQ_LO && MemAck) IR[7:0]  <= MemData;
            if (state == ST_REQ_HI && MemAck) IR[15:8] <= MemData;
            if (state == ST_IDLE && Start) begin
                Error <= 1'b0;
            end else if (abort) begin
                Error <= 1'b1;
            end
        end
    end

    assign ArfOutDSel = OUTSEL_PC;
    assign MemAddr    = MemReq ? ArfOutD : '0;

endmodule
